fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage upstream of the hazard unit: owns PCF, fetches over a req/ack imem port, loads the IF/ID register.
//  Drives fetch_stop to the hazard unit's stop; consumes pcstall, IF_IDstall, flushIF_ID, PCSrc, jump.
//  One-entry skid buffer keeps an acked word during a stall; redirects discard stale fetches.
// PARAMETERS
//  ADDR_WIDTH  16     PC / imem address width (word addressed)
//  INSTR_WIDTH 16     instruction width
//  RESET_PC    16'h0  PCF after reset
//  NOP_INSTR   16'h0  word loaded into IF/ID on bubble/flush
// PORTS
//  clk            in   1            clock, all state on posedge
//  rst            in   1            synchronous, active-high reset
//  pcstall        in   1            hold PC (hazard unit)
//  IF_IDstall     in   1            hold IF/ID (hazard unit)
//  flushIF_ID     in   1            bubble IF/ID (hazard unit, jump)
//  PCSrc          in   1            taken branch, redirect to branch_target
//  branch_target  in   ADDR_WIDTH   branch target
//  jump           in   1            jump, redirect to jump_target
//  jump_target    in   ADDR_WIDTH   jump target
//  imem_req       out  1            fetch request
//  imem_addr      out  ADDR_WIDTH   fetch address
//  imem_ack       in   1            fetch done, imem_rdata valid this cycle
//  imem_rdata     in   INSTR_WIDTH  fetched word
//  fetch_stop     out  1            fetch outstanding, to hazard unit stop
//  pcF            out  ADDR_WIDTH   current fetch PC
//  instrD         out  INSTR_WIDTH  IF/ID instruction
//  pc_plus1D      out  ADDR_WIDTH   IF/ID PC+1
//  validD         out  1            IF/ID holds a real instruction
// BEHAVIOUR
//  Reset: pcF=RESET_PC, instrD=NOP_INSTR, pc_plus1D=0, validD=0, imem_req=0, fetch_stop=0, skid empty, state=S_IDLE.
//  hold = pcstall|IF_IDstall. redir = PCSrc|jump; tgt = PCSrc ? branch_target : jump_target (PCSrc wins).
//  Handshake: imem_req, imem_addr stable until imem_ack; ack earliest 1 cycle after req rises; ack outside S_REQ/S_DROP ignored.
//  fetch_stop = (state==S_REQ) & ~imem_ack; function of state and imem_ack only (no path from hazard inputs).
//  FSM:
//   S_IDLE: req=0; next S_REQ.
//   S_REQ : req=1, addr=pcF.
//     redir & ~ack       -> latch tgt in pend, S_DROP.
//     redir & ack        -> drop word, pcF<=tgt, S_REQ.
//     ack & hold         -> skid<=rdata, S_HOLD, pcF kept.
//     ack & ~hold        -> load IF/ID (rdata, pcF+1, valid=1), pcF<=pcF+1.
//   S_HOLD: req=0. redir -> drop skid, pcF<=tgt, S_REQ; ~hold -> load IF/ID from skid, pcF<=pcF+1, S_REQ.
//   S_DROP: req=1, addr=old pcF. A new redir overwrites pend. ack -> drop word, pcF<=pend, S_REQ.
//  IF/ID priority: rst > (flushIF_ID|redir): NOP, valid=0 > hold: keep > load > none: NOP, valid=0.
//  Fetch latency: addr to instrD = ack cycle + 1. Back-to-back acks give 1 instr/cycle.
//  pcF+1 wraps 2^ADDR_WIDTH-1 -> 0, no flag. rst mid-fetch abandons request (req low next cycle), ack ignored.
// STRUCTURE
//  Shared pkg fetch_pkg: state encodings (S_IDLE/S_REQ/S_HOLD/S_DROP), NOP_INSTR, RESET_PC.
//  Sub-module if_id_reg: IF/ID register (instr, pc_plus1, valid) with flush > stall > load.
//  Top: FSM, pcF, skid, pend regs, target mux.
// TESTING
//  1 Reset then ack every cycle after req -> pcF 0,1,2..; instrD follows rdata 1 cycle after ack; validD=1.
//  2 ack 3 cycles after req -> fetch_stop=1 for 3 cycles, 0 on ack cycle; IF/ID loads once.
//  3 pcstall=1 on ack, 2 cycles -> S_HOLD, req=0, IF/ID held; on release instrD=skid word, no re-fetch.
//  4 PCSrc=1, branch_target=16'h40 while waiting -> S_DROP; stale word dropped; next req addr=16'h40; validD=0.
//  5 PCSrc and jump (jump_target=16'h80) same cycle -> pcF=branch_target; flushIF_ID -> instrD=NOP, validD=0.
//  6 pcF=16'hFFFF acked -> pcF=0, pc_plus1D=0; rst mid-wait -> req=0 next cycle, later ack ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings
// and the default reset PC / bubble instruction used by the stage and IF/ID.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // True in the states that drive a request onto the imem port.
    function automatic logic state_requests(input fetch_state_t s);
        return (s == S_REQ) || (s == S_DROP);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+1 and valid bit.
// Flush beats stall, stall beats load, and no load inserts a bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = 16,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = fetch_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stall,
    input  logic                   load,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic [ADDR_WIDTH-1:0]  pc_plus1_in,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  pc_plus1,
    output logic                   valid
);

    // Update the IF/ID contents with flush > stall > load > bubble priority.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr    <= NOP_INSTR;
            pc_plus1 <= '0;
            valid    <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                instr    <= instr_in;
                pc_plus1 <= pc_plus1_in;
                valid    <= 1'b1;
            end else begin
                instr    <= NOP_INSTR;
                pc_plus1 <= '0;
                valid    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs a req/ack handshake with
// instruction memory, keeps an acked word in a one-entry skid buffer while the
// pipeline is stalled, and discards fetches made stale by a branch or jump.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = 16,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = fetch_pkg::RESET_PC,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = fetch_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pcstall,
    input  logic                   IF_IDstall,
    input  logic                   flushIF_ID,
    input  logic                   PCSrc,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   jump,
    input  logic [ADDR_WIDTH-1:0]  jump_target,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   fetch_stop,
    output logic [ADDR_WIDTH-1:0]  pcF,
    output logic [INSTR_WIDTH-1:0] instrD,
    output logic [ADDR_WIDTH-1:0]  pc_plus1D,
    output logic                   validD
);

    fetch_state_t           state;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [ADDR_WIDTH-1:0]  pend_q;
    logic [INSTR_WIDTH-1:0] skid_q;
    logic                   req_q;

    logic                   hold;
    logic                   redir;
    logic [ADDR_WIDTH-1:0]  tgt;
    logic [ADDR_WIDTH-1:0]  pc_inc;

    logic                   id_flush;
    logic                   id_load;
    logic [INSTR_WIDTH-1:0] id_instr;

    // A taken branch has priority over a jump raised in the same cycle.
    assign hold   = pcstall | IF_IDstall;
    assign redir  = PCSrc | jump;
    assign tgt    = PCSrc ? branch_target : jump_target;
    assign pc_inc = pc_q + ADDR_WIDTH'(1);

    // The address is the fetch PC in every requesting state: S_DROP keeps the
    // old PC on the port until the stale word arrives, the target sits in pend_q.
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pcF       = pc_q;

    // Stop depends only on state and ack so no loop forms through the hazard unit.
    assign fetch_stop = (state == S_REQ) & ~imem_ack;

    // Decide whether IF/ID takes a word this cycle and from where.
    always_comb begin
        id_flush = flushIF_ID | redir;
        id_load  = 1'b0;
        id_instr = skid_q;
        case (state)
            S_REQ: begin
                if (imem_ack && !hold && !redir) begin
                    id_load  = 1'b1;
                    id_instr = imem_rdata;
                end
            end
            S_HOLD: begin
                if (!hold && !redir) begin
                    id_load = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Fetch FSM with registered request, fetch PC, skid word and pending target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            req_q  <= 1'b0;
            pc_q   <= RESET_PC;
            pend_q <= '0;
            skid_q <= NOP_INSTR;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                    req_q <= 1'b1;
                end
                S_REQ: begin
                    if (redir && !imem_ack) begin
                        pend_q <= tgt;
                        state  <= S_DROP;
                    end else if (redir && imem_ack) begin
                        pc_q <= tgt;
                    end else if (imem_ack && hold) begin
                        skid_q <= imem_rdata;
                        state  <= S_HOLD;
                        req_q  <= 1'b0;
                    end else if (imem_ack) begin
                        pc_q <= pc_inc;
                    end
                end
                S_HOLD: begin
                    if (redir) begin
                        pc_q  <= tgt;
                        state <= S_REQ;
                        req_q <= 1'b1;
                    end else if (!hold) begin
                        pc_q  <= pc_inc;
                        state <= S_REQ;
                        req_q <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (redir) begin
                        pend_q <= tgt;
                    end
                    if (imem_ack) begin
                        pc_q  <= redir ? tgt : pend_q;
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .NOP_INSTR   (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .flush       (id_flush),
        .stall       (hold),
        .load        (id_load),
        .instr_in    (id_instr),
        .pc_plus1_in (pc_inc),
        .instr       (instrD),
        .pc_plus1    (pc_plus1D),
        .valid       (validD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle stimulus tables, a
// latency-programmable instruction memory and a scoreboard of IF/ID loads.
module tb_fetch_stage;

    localparam logic        N   = 1'b0;
    localparam logic        Y   = 1'b1;
    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, pcstall, IF_IDstall, flushIF_ID, PCSrc, jump;
    logic [15:0] branch_target, jump_target;
    logic        imem_req, imem_ack, fetch_stop, validD;
    logic [15:0] imem_addr, imem_rdata, pcF, instrD, pc_plus1D;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pcstall       (pcstall),
        .IF_IDstall    (IF_IDstall),
        .flushIF_ID    (flushIF_ID),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .fetch_stop    (fetch_stop),
        .pcF           (pcF),
        .instrD        (instrD),
        .pc_plus1D     (pc_plus1D),
        .validD        (validD)
    );

    // One clock cycle of stimulus plus the PC/request expected after its edge.
    typedef struct packed {
        logic [3:0]  lat;
        logic        rst, pcs, ifs, fl, br, jp;
        logic [15:0] bt, jt;
        logic        fa;
        logic        chk;
        logic [15:0] epc;
        logic        ereq;
    } vec_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc1;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int          mem_lat = 0;
    int          mem_cnt = 0;
    logic        mem_prev_req = 1'b0;

    logic        drop_pending = 1'b0;
    logic        skid_pending = 1'b0;
    logic [15:0] skid_word, skid_addr;
    logic        exp_load, exp_bubble, exp_hold, exp_reset;
    logic [15:0] last_instr = NOP;
    logic        last_valid = 1'b0;
    int          stop_cycles = 0;
    int          load_count  = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic vec_t mk(input int lat,
                                input logic r, pcs, ifs, fl, br, jp,
                                input logic [15:0] bt, jt,
                                input logic fa, chk,
                                input logic [15:0] epc,
                                input logic ereq);
        vec_t v;
        v.lat = 4'(lat); v.rst = r; v.pcs = pcs; v.ifs = ifs; v.fl = fl;
        v.br = br; v.jp = jp; v.bt = bt; v.jt = jt; v.fa = fa;
        v.chk = chk; v.epc = epc; v.ereq = ereq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle of controls, answer as the memory, and predict IF/ID.
    task automatic applyStimulus(input vec_t v);
        logic redir, hold, req;
        exp_t e;
        mem_lat       = int'(v.lat);
        rst           = v.rst;
        pcstall       = v.pcs;
        IF_IDstall    = v.ifs;
        flushIF_ID    = v.fl;
        PCSrc         = v.br;
        jump          = v.jp;
        branch_target = v.bt;
        jump_target   = v.jt;
        redir = v.br | v.jp;
        hold  = v.pcs | v.ifs;
        req   = imem_req;

        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        if (v.fa) begin
            imem_ack   = 1'b1;
            imem_rdata = 16'hBEEF;
        end else if (!req) begin
            mem_cnt = 0;
        end else if (!mem_prev_req) begin
            mem_cnt = 1;
        end else if (mem_cnt >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            mem_cnt    = 0;
        end else begin
            mem_cnt++;
        end
        mem_prev_req = req;

        #1;
        check("fetch_stop", {31'b0, fetch_stop}, {31'b0, req & ~drop_pending & ~imem_ack});
        if (fetch_stop) stop_cycles++;

        exp_load   = 1'b0;
        exp_bubble = 1'b0;
        exp_hold   = 1'b0;
        exp_reset  = v.rst;
        if (v.rst) begin
            sb_q.delete();
            drop_pending = 1'b0;
            skid_pending = 1'b0;
        end else begin
            exp_bubble = v.fl | redir;
            exp_hold   = hold & ~exp_bubble;
            if (req && imem_ack) begin
                if (drop_pending || redir) begin
                    drop_pending = 1'b0;
                end else if (hold) begin
                    skid_word    = imem_rdata;
                    skid_addr    = imem_addr;
                    skid_pending = 1'b1;
                end else if (!v.fl) begin
                    e.instr = imem_rdata;
                    e.pc1   = imem_addr + 16'd1;
                    sb_q.push_back(e);
                    exp_load = 1'b1;
                end
            end else if (req && redir) begin
                drop_pending = 1'b1;
            end else if (skid_pending && !req) begin
                if (redir) begin
                    skid_pending = 1'b0;
                end else if (!hold) begin
                    skid_pending = 1'b0;
                    if (!v.fl) begin
                        e.instr = skid_word;
                        e.pc1   = skid_addr + 16'd1;
                        sb_q.push_back(e);
                        exp_load = 1'b1;
                    end
                end
            end
        end
    endtask

    // Compare IF/ID against the scoreboard and PC/request against the table.
    task automatic checkOutput(input vec_t v);
        exp_t e;
        if (exp_reset) begin
            check("rst_instrD", {16'b0, instrD}, {16'b0, NOP});
            check("rst_pc_plus1D", {16'b0, pc_plus1D}, 32'h0);
            check("rst_validD", {31'b0, validD}, 32'h0);
            last_instr = NOP;
            last_valid = 1'b0;
        end else if (exp_load) begin
            check("sb_has_entry", sb_q.size(), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("load_instrD", {16'b0, instrD}, {16'b0, e.instr});
                check("load_pc_plus1D", {16'b0, pc_plus1D}, {16'b0, e.pc1});
                check("load_validD", {31'b0, validD}, 32'h1);
                last_instr = e.instr;
                last_valid = 1'b1;
            end
        end else if (exp_hold) begin
            check("hold_instrD", {16'b0, instrD}, {16'b0, last_instr});
            check("hold_validD", {31'b0, validD}, {31'b0, last_valid});
        end else begin
            check("bubble_instrD", {16'b0, instrD}, {16'b0, NOP});
            check("bubble_validD", {31'b0, validD}, 32'h0);
            last_instr = NOP;
            last_valid = 1'b0;
        end
        if (validD) load_count++;
        if (v.chk) begin
            check("pcF", {16'b0, pcF}, {16'b0, v.epc});
            check("imem_addr", {16'b0, imem_addr}, {16'b0, v.epc});
            check("imem_req", {31'b0, imem_req}, {31'b0, v.ereq});
        end
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            @(posedge clk);
            #1;
            checkOutput(tbl[i]);
        end
        tbl.delete();
    endtask

    task automatic reset_row();
        tbl.push_back(mk(0, Y,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, N));
        run_table();
        stop_cycles = 0;
        load_count  = 0;
    endtask

    initial begin
        rst = 1'b1; pcstall = 1'b0; IF_IDstall = 1'b0; flushIF_ID = 1'b0;
        PCSrc = 1'b0; jump = 1'b0; branch_target = '0; jump_target = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        @(posedge clk);
        #1;

        // Streaming fetch with ack every cycle, then an IF_IDstall on an ack.
        $display("[TB] stream fetch");
        reset_row();
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0001, Y));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0002, Y));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0003, Y));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0004, Y));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0005, Y));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0006, Y));
        tbl.push_back(mk(0, N,N,Y,N,N,N, 16'h0,16'h0, N, Y, 16'h0006, N));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0007, Y));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0007, Y));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0008, Y));
        run_table();

        // Slow memory: ack three cycles after the request rises.
        $display("[TB] slow ack");
        reset_row();
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0001, Y));
        run_table();
        check("stop_cycles_slow_ack", stop_cycles, 32'd3);
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0001, Y));
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0001, Y));
        run_table();
        check("single_load_slow_ack", load_count, 32'd1);

        // pcstall on the ack cycle for two cycles: skid holds the word.
        $display("[TB] stall into skid");
        reset_row();
        tbl.push_back(mk(1, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(1, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(1, N,Y,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, N));
        tbl.push_back(mk(1, N,Y,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, N));
        tbl.push_back(mk(1, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0001, Y));
        tbl.push_back(mk(1, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0001, Y));
        run_table();

        // Branch while the fetch is outstanding: stale word is discarded.
        $display("[TB] branch during wait");
        reset_row();
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(3, N,N,N,N,Y,N, 16'h0040,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0040, Y));
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0040, Y));
        run_table();

        // Branch and jump together on an ack, then a flush of a valid word.
        $display("[TB] branch beats jump, flush");
        reset_row();
        tbl.push_back(mk(1, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(1, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(1, N,N,N,N,Y,Y, 16'h0040,16'h0080, N, Y, 16'h0040, Y));
        tbl.push_back(mk(1, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0040, Y));
        tbl.push_back(mk(1, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0041, Y));
        tbl.push_back(mk(1, N,N,N,Y,N,N, 16'h0,16'h0, N, Y, 16'h0041, Y));
        tbl.push_back(mk(1, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0042, Y));
        run_table();

        // PC wrap at 16'hFFFF, then reset mid-wait and a stray ack.
        $display("[TB] wrap and reset mid-fetch");
        reset_row();
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        tbl.push_back(mk(0, N,N,N,N,N,Y, 16'h0,16'hFFFF, N, Y, 16'hFFFF, Y));
        tbl.push_back(mk(0, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        run_table();
        check("wrap_pc_plus1D", {16'b0, pc_plus1D}, 32'h0);
        check("wrap_instrD", {16'b0, instrD}, {16'b0, mem_word(16'hFFFF)});
        tbl.push_back(mk(3, Y,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, N));
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, Y, Y, 16'h0000, Y));
        tbl.push_back(mk(3, N,N,N,N,N,N, 16'h0,16'h0, N, Y, 16'h0000, Y));
        run_table();

        check("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
